// File: rtl/result_uart_tx.sv
// 8N1 UART transmitter for recovered candidate passwords: buffers one result,
// sends its bytes followed by CR LF, and can replay the buffered result on request.
module result_uart_tx #(
    parameter int clock_freq = 60000000,
    parameter int baud       = 115200,
    parameter int max_len    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [8*max_len-1:0]   result_data,
    input  logic [3:0]             result_len,
    input  logic                   result_valid,
    output logic                   result_ready,
    input  logic                   rewind,
    output logic                   txd,
    output logic                   busy
);
    // state | meaning
    // IDLE  | line high, ready for a result or a rewind
    // START | start bit (low) for the current byte
    // DATA  | 8 data bits, LSB first
    // STOP  | stop bit (high); then next byte, pending replay, or IDLE

    localparam int DIV   = clock_freq / baud;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(max_len + 2);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       MAX_LEN_4 = 4'(max_len);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [8*max_len-1:0] buf_data;
    logic [3:0]           buf_len;
    logic                 stored;
    logic                 pending;
    logic                 rewind_q;
    logic [DIV_W-1:0]     div_cnt;
    logic [2:0]           bit_cnt;
    logic [IDX_W-1:0]     byte_idx;
    logic [7:0]           shreg;

    logic       accept;
    logic       rew_edge;
    logic       div_done;
    logic       last_byte;
    logic [3:0] len_clamped;
    logic [7:0] accept_byte;
    logic [7:0] first_byte;
    logic [7:0] next_byte;

    // Byte idx of a message: payload bytes, then CR at idx==len, then LF.
    function automatic logic [7:0] msg_byte(input logic [8*max_len-1:0] data,
                                            input logic [3:0] len, input int idx);
        logic [7:0] b;
        b = 8'h0A;
        if (idx == int'(len)) b = 8'h0D;
        for (int k = 0; k < max_len; k++)
            if (k == idx && k < int'(len)) b = data[8*k +: 8];
        return b;
    endfunction

    assign accept      = result_valid && result_ready;
    assign rew_edge    = rewind && !rewind_q;
    assign div_done    = (div_cnt == '0);
    assign len_clamped = (result_len > MAX_LEN_4) ? MAX_LEN_4 : result_len;
    assign accept_byte = msg_byte(result_data, len_clamped, 0);
    assign first_byte  = msg_byte(buf_data, buf_len, 0);
    assign next_byte   = msg_byte(buf_data, buf_len, int'(byte_idx) + 1);
    assign last_byte   = (int'(byte_idx) == int'(buf_len) + 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            txd          <= 1'b1;
            busy         <= 1'b0;
            result_ready <= 1'b0;
            stored       <= 1'b0;
            pending      <= 1'b0;
            rewind_q     <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            byte_idx     <= '0;
            shreg        <= '0;
            buf_data     <= '0;
            buf_len      <= '0;
        end else begin
            rewind_q <= rewind;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // A new result overrides any rewind seen on the same edge.
                        buf_data     <= result_data;
                        buf_len      <= len_clamped;
                        stored       <= 1'b1;
                        pending      <= 1'b0;
                        shreg        <= accept_byte;
                        byte_idx     <= '0;
                        div_cnt      <= DIV_LAST;
                        txd          <= 1'b0;
                        busy         <= 1'b1;
                        result_ready <= 1'b0;
                        state        <= START;
                    end else if (rew_edge && stored) begin
                        shreg        <= first_byte;
                        byte_idx     <= '0;
                        div_cnt      <= DIV_LAST;
                        txd          <= 1'b0;
                        busy         <= 1'b1;
                        result_ready <= 1'b0;
                        state        <= START;
                    end else begin
                        result_ready <= 1'b1;
                    end
                end
                START: begin
                    if (div_done) begin
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        div_cnt <= DIV_LAST;
                        state   <= DATA;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (div_done) begin
                        div_cnt <= DIV_LAST;
                        if (bit_cnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (div_done) begin
                        div_cnt <= DIV_LAST;
                        if (!last_byte) begin
                            byte_idx <= byte_idx + 1'b1;
                            shreg    <= next_byte;
                            txd      <= 1'b0;
                            state    <= START;
                        end else if (pending) begin
                            pending  <= 1'b0;
                            byte_idx <= '0;
                            shreg    <= first_byte;
                            txd      <= 1'b0;
                            state    <= START;
                        end else begin
                            busy         <= 1'b0;
                            result_ready <= 1'b1;
                            state        <= IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Rewinds while busy collapse into a single replay after this message.
            if (state != IDLE && rew_edge && stored) pending <= 1'b1;
        end
    end
endmodule
